td4_sequencer: RTL and testbench

//  Multi-cycle fetch/execute controller for the TD4 4-bit core. Owns PC, IR and carry flag.

---
 rtl/td4_pkg.sv | 40 ++++
 rtl/td4_decoder.sv | 32 +++
 rtl/td4_sequencer.sv | 113 +++++++++++
 tb/tb_td4_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 4-bit core controller.
// Contents: opcode encodings, selector codes, FSM state type and the decoder output bundle.
package td4_pkg;

  localparam logic [3:0] OP_ADD_A   = 4'b0000;
  localparam logic [3:0] OP_MOV_A_B = 4'b0001;
  localparam logic [3:0] OP_IN_A    = 4'b0010;
  localparam logic [3:0] OP_MOV_A   = 4'b0011;
  localparam logic [3:0] OP_MOV_B_A = 4'b0100;
  localparam logic [3:0] OP_ADD_B   = 4'b0101;
  localparam logic [3:0] OP_IN_B    = 4'b0110;
  localparam logic [3:0] OP_MOV_B   = 4'b0111;
  localparam logic [3:0] OP_OUT_B   = 4'b1001;
  localparam logic [3:0] OP_OUT_IM  = 4'b1011;
  localparam logic [3:0] OP_JNC     = 4'b1110;
  localparam logic [3:0] OP_JMP     = 4'b1111;

  // Source selector output-enable codes
  localparam logic [1:0] SEL_A    = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_IN   = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StExec  = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0] sel;
    logic       ld_a;
    logic       ld_b;
    logic       ld_out;
    logic       is_jmp;
    logic       is_jnc;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/td4_decoder.sv
// Combinational TD4 opcode decoder.
// Ports:
//   opcode  in   4   instruction opcode field
//   dec     out  -   {sel, ld_a, ld_b, ld_out, is_jmp, is_jnc, illegal}
module td4_decoder
  import td4_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec     = '0;
    dec.sel = SEL_ZERO;
    case (opcode)
      OP_ADD_A:   begin dec.sel = SEL_A;    dec.ld_a   = 1'b1; end
      OP_MOV_A_B: begin dec.sel = SEL_B;    dec.ld_a   = 1'b1; end
      OP_IN_A:    begin dec.sel = SEL_IN;   dec.ld_a   = 1'b1; end
      OP_MOV_A:   begin dec.sel = SEL_ZERO; dec.ld_a   = 1'b1; end
      OP_MOV_B_A: begin dec.sel = SEL_A;    dec.ld_b   = 1'b1; end
      OP_ADD_B:   begin dec.sel = SEL_B;    dec.ld_b   = 1'b1; end
      OP_IN_B:    begin dec.sel = SEL_IN;   dec.ld_b   = 1'b1; end
      OP_MOV_B:   begin dec.sel = SEL_ZERO; dec.ld_b   = 1'b1; end
      OP_OUT_B:   begin dec.sel = SEL_B;    dec.ld_out = 1'b1; end
      OP_OUT_IM:  begin dec.sel = SEL_ZERO; dec.ld_out = 1'b1; end
      OP_JMP:     begin dec.sel = SEL_ZERO; dec.is_jmp = 1'b1; end
      OP_JNC:     begin dec.sel = SEL_ZERO; dec.is_jnc = 1'b1; end
      default:    dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/td4_sequencer.sv
// TD4 fetch/execute controller: owns PC, IR and the carry flag, fetches instructions over a
// req/valid ROM interface and drives selector, immediate and register load enables.
// Ports:
//   clk        in   1     clock
//   n_rst      in   1     synchronous active-low reset
//   run        in   1     1 = execute, 0 = stop in idle after current instruction
//   rom_addr   out  N     fetch address (PC)
//   rom_req    out  1     fetch request, high throughout fetch
//   rom_data   in   4+N   instruction word
//   rom_valid  in   1     rom_data valid
//   sel        out  2     source selector (A/B/IN/zero)
//   imm        out  N     immediate to ALU
//   alu_sum    in   N     ALU result
//   alu_carry  in   1     ALU carry out
//   ld_a/ld_b/ld_out out  register load enables (exec only)
//   c_flag     out  1     registered carry flag
//   illegal    out  1     pulse in exec for an undefined opcode
module td4_sequencer
  import td4_pkg::*;
#(
  parameter int unsigned    N        = 4,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           run,
  output logic [N-1:0]   rom_addr,
  output logic           rom_req,
  input  logic [N+3:0]   rom_data,
  input  logic           rom_valid,
  output logic [1:0]     sel,
  output logic [N-1:0]   imm,
  input  logic [N-1:0]   alu_sum,
  input  logic           alu_carry,
  output logic           ld_a,
  output logic           ld_b,
  output logic           ld_out,
  output logic           c_flag,
  output logic           illegal
);

  state_e       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N+3:0] ir_q, ir_d;
  logic         c_q, c_d;
  dec_t         dec;
  logic         jump_taken;

  td4_decoder u_decoder (
    .opcode (ir_q[N+3:N]),
    .dec    (dec)
  );

  // JNC tests the carry flag as it was before this instruction updates it
  assign jump_taken = dec.is_jmp | (dec.is_jnc & ~c_q);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    c_d     = c_q;
    rom_req = 1'b0;
    sel     = SEL_ZERO;
    imm     = '0;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_out  = 1'b0;
    illegal = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        rom_req = 1'b1;
        if (rom_valid) begin
          ir_d    = rom_data;
          state_d = StExec;
        end
      end
      StExec: begin
        sel     = dec.sel;
        imm     = ir_q[N-1:0];
        ld_a    = dec.ld_a;
        ld_b    = dec.ld_b;
        ld_out  = dec.ld_out;
        illegal = dec.illegal;
        if (!dec.illegal) c_d = alu_carry;
        pc_d    = jump_taken ? alu_sum : pc_q + N'(1);
        state_d = run ? StFetch : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rom_addr = pc_q;
  assign c_flag   = c_q;

endmodule

// File: tb/tb_td4_sequencer.sv
// Self-checking bench for td4_sequencer: the bench plays ROM and ALU, predicts each
// instruction's exec-cycle outputs and resulting PC/carry, and queues them for comparison.
module tb_td4_sequencer;

  logic       clk;
  logic       n_rst;
  logic       run;
  logic [3:0] rom_addr;
  logic       rom_req;
  logic [7:0] rom_data;
  logic       rom_valid;
  logic [1:0] sel;
  logic [3:0] imm;
  logic [3:0] alu_sum;
  logic       alu_carry;
  logic       ld_a, ld_b, ld_out, c_flag, illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] imm;
    logic       ld_a;
    logic       ld_b;
    logic       ld_out;
    logic       illegal;
    logic [3:0] pc;
    logic       c;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_pc;
  logic       m_c;

  td4_sequencer #(.N(4), .RESET_PC(4'd0)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .run       (run),
    .rom_addr  (rom_addr),
    .rom_req   (rom_req),
    .rom_data  (rom_data),
    .rom_valid (rom_valid),
    .sel       (sel),
    .imm       (imm),
    .alu_sum   (alu_sum),
    .alu_carry (alu_carry),
    .ld_a      (ld_a),
    .ld_b      (ld_b),
    .ld_out    (ld_out),
    .c_flag    (c_flag),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(logic [7:0] w, logic [3:0] pc, logic c,
                                 logic [3:0] sum, logic carry);
    exp_t e;
    logic jump;
    e.sel = 2'd3; e.imm = w[3:0]; e.ld_a = 0; e.ld_b = 0; e.ld_out = 0; e.illegal = 0;
    jump = 0;
    case (w[7:4])
      4'h0: begin e.sel = 2'd0; e.ld_a = 1; end
      4'h1: begin e.sel = 2'd1; e.ld_a = 1; end
      4'h2: begin e.sel = 2'd2; e.ld_a = 1; end
      4'h3: begin e.sel = 2'd3; e.ld_a = 1; end
      4'h4: begin e.sel = 2'd0; e.ld_b = 1; end
      4'h5: begin e.sel = 2'd1; e.ld_b = 1; end
      4'h6: begin e.sel = 2'd2; e.ld_b = 1; end
      4'h7: begin e.sel = 2'd3; e.ld_b = 1; end
      4'h9: begin e.sel = 2'd1; e.ld_out = 1; end
      4'hB: begin e.sel = 2'd3; e.ld_out = 1; end
      4'hF: jump = 1;
      4'hE: jump = ~c;
      default: e.illegal = 1;
    endcase
    e.c  = e.illegal ? c : carry;
    e.pc = jump ? sum : pc + 4'd1;
    return e;
  endfunction

  // Wait (bounded) for a fetch, optionally hold off valid, then check exec and aftermath.
  task automatic run_instr(input logic [7:0] w, input int delay, input logic [3:0] sum,
                           input logic carry, input bit drop_run);
    exp_t e;
    int   waited = 0;
    while (!rom_req && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (rom_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_timeout: rom_req=%b after %0d cycles, required 1", rom_req, waited);
    end
    checks++;
    if (rom_addr !== m_pc) begin
      errors++;
      $display("FAIL fetch_addr: rom_addr=%0h required %0h", rom_addr, m_pc);
    end
    for (int i = 0; i < delay; i++) begin
      rom_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (rom_req !== 1'b1 || rom_addr !== m_pc) begin
        errors++;
        $display("FAIL fetch_hold: req=%b addr=%0h required req=1 addr=%0h",
                 rom_req, rom_addr, m_pc);
      end
    end
    rom_valid = 1'b1;
    rom_data  = w;
    alu_sum   = sum;
    alu_carry = carry;
    sb.push_back(model(w, m_pc, m_c, sum, carry));
    @(negedge clk);
    rom_valid = 1'b0;
    if (drop_run) run = 1'b0;
    e = sb.pop_front();
    checks++;
    if (rom_req !== 1'b0 || imm !== e.imm || ld_a !== e.ld_a || ld_b !== e.ld_b ||
        ld_out !== e.ld_out || illegal !== e.illegal || (!e.illegal && sel !== e.sel)) begin
      errors++;
      $display("FAIL exec_%02h: req=%b sel=%0d imm=%0h ld=%b%b%b ill=%b required req=0 sel=%0d imm=%0h ld=%b%b%b ill=%b",
               w, rom_req, sel, imm, ld_a, ld_b, ld_out, illegal,
               e.sel, e.imm, e.ld_a, e.ld_b, e.ld_out, e.illegal);
    end
    @(negedge clk);
    m_pc = e.pc;
    m_c  = e.c;
    checks++;
    if (c_flag !== m_c || rom_addr !== m_pc || rom_req !== run) begin
      errors++;
      $display("FAIL after_%02h: c=%b pc=%0h req=%b required c=%b pc=%0h req=%b",
               w, c_flag, rom_addr, rom_req, m_c, m_pc, run);
    end
    checks++;
    if (sel !== 2'd3 || imm !== 4'd0 || {ld_a, ld_b, ld_out, illegal} !== 4'b0) begin
      errors++;
      $display("FAIL idle_outputs_%02h: sel=%0d imm=%0h ld/ill=%b%b%b%b required 3 0 0000",
               w, sel, imm, ld_a, ld_b, ld_out, illegal);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; run = 1'b1; rom_valid = 1'b1; rom_data = 8'h35;
    alu_sum = 4'h0; alu_carry = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (rom_req !== 1'b0 || rom_addr !== 4'd0 || sel !== 2'd3 || imm !== 4'd0 ||
        {ld_a, ld_b, ld_out, illegal} !== 4'b0 || c_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset: req=%b addr=%0h sel=%0d imm=%0h ld/ill=%b%b%b%b c=%b required 0 0 3 0 0000 0",
               rom_req, rom_addr, sel, imm, ld_a, ld_b, ld_out, illegal, c_flag);
    end
    rom_valid = 1'b0;
    n_rst     = 1'b1;
    m_pc      = 4'd0;
    m_c       = 1'b0;
  endtask

  task automatic test_mov();
    run_instr(8'h35, 0, 4'd5, 1'b0, 0);
  endtask

  task automatic test_carry_jnc();
    run_instr(8'h0F, 0, 4'd4, 1'b1, 0);  // ADD A,F -> carry set
    run_instr(8'hE3, 0, 4'd3, 1'b0, 0);  // JNC not taken
    run_instr(8'h01 | 8'h00, 0, 4'd1, 1'b0, 0);  // ADD A,1 with no carry
    run_instr(8'hE3, 0, 4'd3, 1'b0, 0);  // JNC taken -> PC 3
  endtask

  task automatic test_wrap_jmp();
    run_instr(8'hFF, 0, 4'hF, 1'b0, 0);  // JMP F
    run_instr(8'h00, 0, 4'h0, 1'b0, 0);  // PC wraps 15 -> 0
    run_instr(8'hF9, 0, 4'h9, 1'b0, 0);  // JMP 9
  endtask

  task automatic test_delay();
    run_instr(8'h72, 5, 4'd2, 1'b0, 0);
  endtask

  task automatic test_illegal();
    run_instr(8'h5F, 0, 4'd3, 1'b1, 0);  // set carry
    run_instr(8'h80, 0, 4'd7, 1'b0, 0);  // undefined: carry must hold
  endtask

  task automatic test_reset_mid_fetch();
    int waited = 0;
    while (!rom_req && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_rst = 1'b0; rom_valid = 1'b1; rom_data = 8'hF5; run = 1'b0;
    @(negedge clk);
    n_rst = 1'b1; rom_valid = 1'b0;
    m_pc = 4'd0; m_c = 1'b0;
    checks++;
    if (rom_req !== 1'b0 || rom_addr !== 4'd0 || c_flag !== 1'b0 || sel !== 2'd3) begin
      errors++;
      $display("FAIL reset_mid_fetch: req=%b addr=%0h c=%b sel=%0d required 0 0 0 3",
               rom_req, rom_addr, c_flag, sel);
    end
    @(negedge clk);
    checks++;
    if (rom_req !== 1'b0 || ld_a !== 1'b0 || rom_addr !== 4'd0) begin
      errors++;
      $display("FAIL stay_idle: req=%b ld_a=%b addr=%0h required 0 0 0", rom_req, ld_a, rom_addr);
    end
  endtask

  task automatic test_run_drop();
    run = 1'b1;
    run_instr(8'h3A, 0, 4'hA, 1'b0, 1);
    repeat (2) @(negedge clk);
    checks++;
    if (rom_req !== 1'b0 || rom_addr !== m_pc) begin
      errors++;
      $display("FAIL run_drop_idle: req=%b addr=%0h required 0 %0h", rom_req, rom_addr, m_pc);
    end
    run = 1'b1;
    run_instr(8'h71, 0, 4'd1, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      run_instr(8'($urandom), 0, 4'($urandom), 1'($urandom), 0);
    end
  endtask

  initial begin
    test_reset();
    test_mov();
    test_carry_jnc();
    test_wrap_jmp();
    test_delay();
    test_illegal();
    test_reset_mid_fetch();
    test_run_drop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
